// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between the multi-cycle controller (master)
// and the datapath / memory side (slave).
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Opcode;
   logic             instr_ready;
   logic             data_ready;
   logic             branch_taken;
   logic             instr_req;
   logic             IRWrite;
   logic             PCWrite;
   logic [1:0]       PCSrc;
   logic             ALUSrcA;
   logic             ALUSrc;
   logic [1:0]       ALUOp;
   logic [1:0]       ResultSrc;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             Branch;
   logic             jmp;
   logic             jmpr;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instret;
   logic [2:0]       state_o;

   modport master (
      input  Opcode, instr_ready, data_ready, branch_taken,
      output instr_req, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrc, ALUOp, ResultSrc,
             RegWrite, MemRead, MemWrite, Branch, jmp, jmpr, trap, trap_cause,
             instret, state_o
   );

   modport slave (
      output Opcode, instr_ready, data_ready, branch_taken,
      input  instr_req, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrc, ALUOp, ResultSrc,
             RegWrite, MemRead, MemWrite, Branch, jmp, jmpr, trap, trap_cause,
             instret, state_o
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V main control FSM: FETCH/DECODE/EXEC/MEM/WB with ready
// handshakes, memory-wait watchdog, sticky trap and retired-instruction counter.
module multicycle_controller #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 32,
   parameter bit SUPPORT_UPPER  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_controller_if.master bus
);
   localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      C_ILL = 4'd0, C_R = 4'd1, C_I = 4'd2, C_LW = 4'd3, C_SW = 4'd4,
      C_BR = 4'd5, C_JAL = 4'd6, C_JALR = 4'd7, C_LUI = 4'd8, C_AUIPC = 4'd9
   } class_e;

   function automatic class_e decode_op(input logic [6:0] op);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LW;
         7'b0100011: return C_SW;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         7'b0110111: return SUPPORT_UPPER ? C_LUI : C_ILL;
         7'b0010111: return SUPPORT_UPPER ? C_AUIPC : C_ILL;
         default:    return C_ILL;
      endcase
   endfunction

   state_e            state_q, state_d;
   class_e            class_q, class_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              trap_q, trap_d;
   logic [1:0]        cause_q, cause_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              retire_s;

   logic       instr_req_s, ir_write_s, pc_write_s, alu_src_a_s, alu_src_s;
   logic [1:0] pc_src_s, alu_op_s, result_src_s;
   logic       reg_write_s, mem_read_s, mem_write_s, branch_s, jmp_s, jmpr_s;

   // Next-state, watchdog, trap and control decode; controls are held low while reset is asserted.
   always_comb begin
      state_d      = state_q;
      class_d      = class_q;
      wait_d       = '0;
      trap_d       = trap_q;
      cause_d      = cause_q;
      retire_s     = 1'b0;
      instr_req_s  = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      pc_src_s     = 2'b00;
      alu_src_a_s  = 1'b0;
      alu_src_s    = 1'b0;
      alu_op_s     = 2'b00;
      result_src_s = 2'b00;
      reg_write_s  = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      branch_s     = 1'b0;
      jmp_s        = 1'b0;
      jmpr_s       = 1'b0;
      if (reset) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               instr_req_s = 1'b1;
               if (bus.instr_ready) begin
                  ir_write_s = 1'b1;
                  state_d    = S_DECODE;
               end else if (wait_q == WAIT_LAST) begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'b10;
               end else begin
                  wait_d = wait_q + WAIT_W'(1'b1);
               end
            end
            S_DECODE: begin
               class_d = decode_op(bus.Opcode);
               if (class_d == C_ILL) begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'b01;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               case (class_q)
                  C_R: begin
                     alu_op_s = 2'b10;
                     state_d  = S_WB;
                  end
                  C_I: begin
                     alu_op_s  = 2'b10;
                     alu_src_s = 1'b1;
                     state_d   = S_WB;
                  end
                  C_LUI: begin
                     alu_src_s = 1'b1;
                     alu_op_s  = 2'b11;
                     state_d   = S_WB;
                  end
                  C_AUIPC: begin
                     alu_src_a_s = 1'b1;
                     alu_src_s   = 1'b1;
                     state_d     = S_WB;
                  end
                  C_LW, C_SW: begin
                     alu_src_s = 1'b1;
                     state_d   = S_MEM;
                  end
                  C_BR: begin
                     branch_s   = 1'b1;
                     alu_op_s   = 2'b01;
                     pc_write_s = 1'b1;
                     pc_src_s   = bus.branch_taken ? 2'b01 : 2'b00;
                     retire_s   = 1'b1;
                     state_d    = S_FETCH;
                  end
                  C_JAL: begin
                     jmp_s        = 1'b1;
                     reg_write_s  = 1'b1;
                     result_src_s = 2'b10;
                     pc_write_s   = 1'b1;
                     pc_src_s     = 2'b01;
                     retire_s     = 1'b1;
                     state_d      = S_FETCH;
                  end
                  C_JALR: begin
                     jmpr_s       = 1'b1;
                     alu_src_s    = 1'b1;
                     reg_write_s  = 1'b1;
                     result_src_s = 2'b10;
                     pc_write_s   = 1'b1;
                     pc_src_s     = 2'b10;
                     retire_s     = 1'b1;
                     state_d      = S_FETCH;
                  end
                  default: begin
                     state_d = S_TRAP;
                     trap_d  = 1'b1;
                     cause_d = 2'b01;
                  end
               endcase
            end
            S_MEM: begin
               if (class_q == C_LW) begin
                  mem_read_s = 1'b1;
               end else begin
                  mem_write_s = 1'b1;
               end
               if (bus.data_ready) begin
                  if (class_q == C_LW) begin
                     state_d = S_WB;
                  end else begin
                     pc_write_s = 1'b1;
                     retire_s   = 1'b1;
                     state_d    = S_FETCH;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  state_d = S_TRAP;
                  trap_d  = 1'b1;
                  cause_d = 2'b11;
               end else begin
                  wait_d = wait_q + WAIT_W'(1'b1);
               end
            end
            S_WB: begin
               reg_write_s  = 1'b1;
               result_src_s = (class_q == C_LW) ? 2'b01 : 2'b00;
               pc_write_s   = 1'b1;
               retire_s     = 1'b1;
               state_d      = S_FETCH;
            end
            S_TRAP: begin
               state_d = S_TRAP;
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
      end
      instret_d = retire_s ? instret_q + CNT_W'(1'b1) : instret_q;
   end

   // State, class, watchdog, trap and retire-count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         class_q   <= C_ILL;
         wait_q    <= '0;
         trap_q    <= 1'b0;
         cause_q   <= 2'b00;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         wait_q    <= wait_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   assign bus.instr_req  = instr_req_s;
   assign bus.IRWrite    = ir_write_s;
   assign bus.PCWrite    = pc_write_s;
   assign bus.PCSrc      = pc_src_s;
   assign bus.ALUSrcA    = alu_src_a_s;
   assign bus.ALUSrc     = alu_src_s;
   assign bus.ALUOp      = alu_op_s;
   assign bus.ResultSrc  = result_src_s;
   assign bus.RegWrite   = reg_write_s;
   assign bus.MemRead    = mem_read_s;
   assign bus.MemWrite   = mem_write_s;
   assign bus.Branch     = branch_s;
   assign bus.jmp        = jmp_s;
   assign bus.jmpr       = jmpr_s;
   assign bus.trap       = trap_q;
   assign bus.trap_cause = cause_q;
   assign bus.instret    = instret_q;
   assign bus.state_o    = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two configurations (A: upper ops
// legal, 32-bit counter; B: upper ops illegal, 2-bit counter), both with a 4-cycle watchdog.
module tb_multicycle_controller;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   multicycle_controller_if #(.CNT_W(32)) if_a ();
   multicycle_controller_if #(.CNT_W(2))  if_b ();

   multicycle_controller #(.TIMEOUT_CYCLES(4), .CNT_W(32), .SUPPORT_UPPER(1'b1)) u_a (
      .clk(clk), .reset(rst_a), .bus(if_a.master));
   multicycle_controller #(.TIMEOUT_CYCLES(4), .CNT_W(2), .SUPPORT_UPPER(1'b0)) u_b (
      .clk(clk), .reset(rst_b), .bus(if_b.master));

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

   // Control vector layout: instr_req IRWrite PCWrite PCSrc[2] ALUSrcA ALUSrc ALUOp[2]
   // ResultSrc[2] RegWrite MemRead MemWrite Branch jmp jmpr trap trap_cause[2]
   localparam logic [19:0] IREQ = 20'h80000, IRW = 20'h40000, PCW = 20'h20000;
   localparam logic [19:0] ASA = 20'h04000, ASRC = 20'h02000, RW = 20'h00100;
   localparam logic [19:0] MR = 20'h00080, MW = 20'h00040, BRN = 20'h00020;
   localparam logic [19:0] JMP = 20'h00010, JMPR = 20'h00008, TRP = 20'h00004;

   function automatic logic [19:0] pcs(input logic [1:0] v);
      return {3'b000, v, 15'h0000};
   endfunction
   function automatic logic [19:0] aop(input logic [1:0] v);
      return {7'h00, v, 11'h000};
   endfunction
   function automatic logic [19:0] rsr(input logic [1:0] v);
      return {9'h000, v, 9'h000};
   endfunction
   function automatic logic [19:0] cse(input logic [1:0] v);
      return {18'h00000, v};
   endfunction

   wire [19:0] obs_a = {if_a.instr_req, if_a.IRWrite, if_a.PCWrite, if_a.PCSrc, if_a.ALUSrcA,
                        if_a.ALUSrc, if_a.ALUOp, if_a.ResultSrc, if_a.RegWrite, if_a.MemRead,
                        if_a.MemWrite, if_a.Branch, if_a.jmp, if_a.jmpr, if_a.trap, if_a.trap_cause};
   wire [19:0] obs_b = {if_b.instr_req, if_b.IRWrite, if_b.PCWrite, if_b.PCSrc, if_b.ALUSrcA,
                        if_b.ALUSrc, if_b.ALUOp, if_b.ResultSrc, if_b.RegWrite, if_b.MemRead,
                        if_b.MemWrite, if_b.Branch, if_b.jmp, if_b.jmpr, if_b.trap, if_b.trap_cause};

   typedef struct {
      bit          sel;
      logic [2:0]  st;
      logic [19:0] ctl;
      logic [31:0] ret;
      int          idx;
   } exp_t;

   exp_t        sb[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          n_step  = 0;
   bit          cur_sel = 1'b0;
   logic [31:0] exp_ret = 32'd0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // One cycle of stimulus: drive inputs at the falling edge and queue what this cycle must show.
   task automatic step(input logic rst, input logic [6:0] op, input logic ir, input logic dr,
                       input logic bt, input logic [2:0] st, input logic [19:0] ctl, input bit retire);
      exp_t e;
      @(negedge clk);
      rst_a = (cur_sel == 1'b0) ? rst : 1'b1;
      rst_b = (cur_sel == 1'b1) ? rst : 1'b1;
      if_a.Opcode = op; if_a.instr_ready = ir; if_a.data_ready = dr; if_a.branch_taken = bt;
      if_b.Opcode = op; if_b.instr_ready = ir; if_b.data_ready = dr; if_b.branch_taken = bt;
      e.sel = cur_sel; e.st = st; e.ctl = ctl; e.ret = exp_ret; e.idx = n_step;
      n_step++;
      sb.push_back(e);
      if (rst) exp_ret = 32'd0;
      else if (retire) exp_ret = (cur_sel == 1'b0) ? exp_ret + 32'd1 : ((exp_ret + 32'd1) & 32'd3);
   endtask

   task automatic start_session(input bit s);
      cur_sel = s;
      exp_ret = 32'd0;
      step(1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0, 20'h00000, 1'b0);
   endtask

   task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
      for (int i = 0; i < fw; i++) step(1'b0, op, 1'b0, 1'b1, bt, 3'd0, IREQ, 1'b0);
      step(1'b0, op, 1'b1, 1'b1, bt, 3'd0, IREQ | IRW, 1'b0);
      step(1'b0, op, 1'b1, 1'b1, bt, 3'd1, 20'h00000, 1'b0);
      case (op)
         OP_R:     step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, aop(2'b10), 1'b0);
         OP_I:     step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, ASRC | aop(2'b10), 1'b0);
         OP_LUI:   step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, ASRC | aop(2'b11), 1'b0);
         OP_AUIPC: step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, ASA | ASRC, 1'b0);
         OP_LW, OP_SW: begin
            step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, ASRC, 1'b0);
            for (int i = 0; i < mw; i++) step(1'b0, op, 1'b1, 1'b0, bt, 3'd3, (op == OP_LW) ? MR : MW, 1'b0);
            if (op == OP_LW) step(1'b0, op, 1'b1, 1'b1, bt, 3'd3, MR, 1'b0);
            else             step(1'b0, op, 1'b1, 1'b1, bt, 3'd3, MW | PCW, 1'b1);
         end
         OP_BR:   step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, BRN | aop(2'b01) | PCW | pcs({1'b0, bt}), 1'b1);
         OP_JAL:  step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, JMP | RW | rsr(2'b10) | PCW | pcs(2'b01), 1'b1);
         OP_JALR: step(1'b0, op, 1'b1, 1'b1, bt, 3'd2, JMPR | ASRC | RW | rsr(2'b10) | PCW | pcs(2'b10), 1'b1);
         default: ;
      endcase
      if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_AUIPC || op == OP_LW)
         step(1'b0, op, 1'b1, 1'b1, bt, 3'd4, RW | PCW | rsr((op == OP_LW) ? 2'b01 : 2'b00), 1'b1);
   endtask

   task automatic trap_hold(input logic [6:0] op, input logic [1:0] c);
      for (int i = 0; i < 2; i++) step(1'b0, op, 1'b1, 1'b1, 1'b0, 3'd5, TRP | cse(c), 1'b0);
      step(1'b1, op, 1'b1, 1'b1, 1'b0, 3'd5, TRP | cse(c), 1'b0);
   endtask

   task automatic illegal(input logic [6:0] op);
      step(1'b0, op, 1'b1, 1'b1, 1'b0, 3'd0, IREQ | IRW, 1'b0);
      step(1'b0, op, 1'b1, 1'b1, 1'b0, 3'd1, 20'h00000, 1'b0);
      trap_hold(op, 2'b01);
   endtask

   // Compare each queued expectation against the selected instance, mid-cycle after inputs settle.
   initial begin
      exp_t r;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            r = sb.pop_front();
            if (r.sel == 1'b0) begin
               chk_eq($sformatf("a%0d.state", r.idx), {29'd0, if_a.state_o}, {29'd0, r.st});
               chk_eq($sformatf("a%0d.ctl", r.idx), {12'd0, obs_a}, {12'd0, r.ctl});
               chk_eq($sformatf("a%0d.instret", r.idx), if_a.instret, r.ret);
            end else begin
               chk_eq($sformatf("b%0d.state", r.idx), {29'd0, if_b.state_o}, {29'd0, r.st});
               chk_eq($sformatf("b%0d.ctl", r.idx), {12'd0, obs_b}, {12'd0, r.ctl});
               chk_eq($sformatf("b%0d.instret", r.idx), {30'd0, if_b.instret}, r.ret);
            end
         end
      end
   end

   initial begin
      if_a.Opcode = 7'd0; if_a.instr_ready = 1'b0; if_a.data_ready = 1'b0; if_a.branch_taken = 1'b0;
      if_b.Opcode = 7'd0; if_b.instr_ready = 1'b0; if_b.data_ready = 1'b0; if_b.branch_taken = 1'b0;
      repeat (3) @(negedge clk);

      start_session(1'b0);
      instr(OP_R, 0, 0, 1'b0);
      instr(OP_LW, 0, 3, 1'b0);
      instr(OP_BR, 0, 0, 1'b1);
      instr(OP_BR, 0, 0, 1'b0);
      instr(OP_I, 2, 0, 1'b0);
      instr(OP_LUI, 0, 0, 1'b0);
      instr(OP_AUIPC, 1, 0, 1'b0);
      instr(OP_SW, 0, 1, 1'b0);
      instr(OP_JAL, 0, 0, 1'b0);
      instr(OP_JALR, 0, 0, 1'b0);
      instr(OP_R, 3, 0, 1'b0);
      instr(OP_SW, 0, 3, 1'b0);

      // Reset in MEM of a store, then let the fetch watchdog expire.
      step(1'b0, OP_SW, 1'b1, 1'b1, 1'b0, 3'd0, IREQ | IRW, 1'b0);
      step(1'b0, OP_SW, 1'b1, 1'b1, 1'b0, 3'd1, 20'h00000, 1'b0);
      step(1'b0, OP_SW, 1'b1, 1'b1, 1'b0, 3'd2, ASRC, 1'b0);
      step(1'b0, OP_SW, 1'b1, 1'b0, 1'b0, 3'd3, MW, 1'b0);
      step(1'b1, OP_SW, 1'b1, 1'b0, 1'b0, 3'd3, 20'h00000, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, OP_R, 1'b0, 1'b1, 1'b0, 3'd0, IREQ, 1'b0);
      trap_hold(OP_R, 2'b10);

      instr(OP_JAL, 0, 0, 1'b0);
      step(1'b0, OP_LW, 1'b1, 1'b1, 1'b0, 3'd0, IREQ | IRW, 1'b0);
      step(1'b0, OP_LW, 1'b1, 1'b1, 1'b0, 3'd1, 20'h00000, 1'b0);
      step(1'b0, OP_LW, 1'b1, 1'b1, 1'b0, 3'd2, ASRC, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, OP_LW, 1'b1, 1'b0, 1'b0, 3'd3, MR, 1'b0);
      trap_hold(OP_LW, 2'b11);

      illegal(7'b0000000);

      start_session(1'b1);
      for (int i = 0; i < 5; i++) instr(OP_JAL, 0, 0, 1'b0);
      illegal(OP_LUI);

      repeat (2) @(negedge clk);
      #4;
      chk_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle main control FSM for the RISC-V core; successor to the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, with ready handshakes on instruction and data memory.
- Adds LUI/AUIPC (parameter-gated), a memory-wait watchdog, a sticky trap and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 16, maximum wait cycles for instr_ready/data_ready before trapping; must be >=1.
- CNT_W, 32, width of instret counter.
- SUPPORT_UPPER, 1, 1 = LUI (0110111) and AUIPC (0010111) legal; 0 = both trap as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  7  instruction opcode from IR; valid from DECODE onward.
- instr_ready  in  1  instruction memory has data this cycle.
- data_ready  in  1  data memory completes access this cycle.
- branch_taken  in  1  ALU branch comparison result; sampled in EXEC.
- instr_req  out  1  instruction fetch request.
- IRWrite  out  1  load IR.
- PCWrite  out  1  update PC.
- PCSrc  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result & ~1 (JALR).
- ALUSrcA  out  1  0 rs1, 1 PC (AUIPC).
- ALUSrc  out  1  0 rs2, 1 immediate.
- ALUOp  out  2  00 add, 01 branch compare, 10 R/I funct decode, 11 pass B (LUI).
- ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4.
- RegWrite, MemRead, MemWrite, Branch, jmp, jmpr  out  1 each  as named.
- trap  out  1  sticky error flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout.
- instret  out  CNT_W  retired-instruction count.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (sampled on clk edge): state=FETCH, class register cleared, wait counter=0, trap=0, trap_cause=00, instret=0.
- Outputs are decoded from the state, the latched class and the ready inputs. Any output not listed for a state is 0.
- Legal classes: R(0110011), I(0010011), LW(0000011), SW(0100011), BR(1100011), JAL(1101111), JALR(1100111), plus LUI/AUIPC when SUPPORT_UPPER=1.
- FETCH: instr_req=1. When instr_ready=1: IRWrite=1 in the same cycle, next state DECODE. The wait counter increments on each cycle with instr_ready=0; reaching TIMEOUT_CYCLES -> TRAP with cause 10.
- DECODE: latch class from Opcode. Illegal -> TRAP with cause 01; otherwise -> EXEC. One cycle, no side effects.
- EXEC by class:
  - R: ALUOp=10 -> WB.
  - I: ALUOp=10, ALUSrc=1 -> WB.
  - LUI: ALUSrc=1, ALUOp=11 -> WB.
  - AUIPC: ALUSrcA=1, ALUSrc=1, ALUOp=00 -> WB.
  - LW/SW: ALUSrc=1, ALUOp=00 -> MEM.
  - BR: Branch=1, ALUOp=01, PCWrite=1, PCSrc=01 if branch_taken else 00; retires -> FETCH.
  - JAL: jmp=1, RegWrite=1, ResultSrc=10, PCWrite=1, PCSrc=01; retires -> FETCH.
  - JALR: jmpr=1, ALUSrc=1, ALUOp=00, RegWrite=1, ResultSrc=10, PCWrite=1, PCSrc=10; retires -> FETCH.
- MEM: MemRead=1 (LW) or MemWrite=1 (SW), held until data_ready=1.
  - LW -> WB.
  - SW: PCWrite=1, PCSrc=00 in the data_ready cycle; retires -> FETCH.
  - Timeout as in FETCH -> TRAP with cause 11.
- WB: RegWrite=1, ResultSrc=01 for LW else 00, PCWrite=1, PCSrc=00; retires -> FETCH.
- Wait counter clears on every state change.
- instret increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- TRAP: trap=1, all control outputs 0, PCWrite=0, instret frozen. Exit only through reset.
- Reset asserted mid-instruction aborts it: no RegWrite/MemWrite/PCWrite in the reset cycle, and instret does not increment.
- A ready input arriving in the same cycle the counter reaches the limit counts as success; the access completes, no trap.
- Latency with zero memory wait:
  - BR/JAL/JALR: 3 cycles.
  - R/I/LUI/AUIPC: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.

Test Plan:
- Reset, then ADD (0110011) with ready held at 1 -> states 0,1,2,4,0; RegWrite=1 only in WB; instret=1 after 4 cycles.
- LW with data_ready low for 3 MEM cycles -> MemRead held 4 cycles, then WB with ResultSrc=01; instret=1 after 8 cycles.
- BEQ with branch_taken=1, then again with 0 -> PCSrc=01, then 00; PCWrite=1 in EXEC; 3 cycles each.
- Opcode 0110111 with SUPPORT_UPPER=0 -> TRAP, trap_cause=01, instret unchanged; instr_req stays 0 until reset.
- instr_ready held at 0 with TIMEOUT_CYCLES=4 -> trap=1, cause 10 after 4 FETCH cycles. Repeat with ready in the 4th cycle -> DECODE, no trap.
- Reset asserted in MEM during SW -> MemWrite=0 next cycle, state FETCH, instret=0. CNT_W=2 with 5 JALs -> instret=1 (wrap).
